// File: rtl/mbtrain_busy_driver.sv
// mbtrain_busy_driver: busy handshake around N pattern/compare iterations with per-iteration timeout and abort
module mbtrain_busy_driver #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES = 4,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ITER_W-1:0] i_iterations,
  input  logic              i_done,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_pattern_en,
  output logic [ITER_W-1:0] o_iter_count,
  output logic              o_timeout,
  output logic              o_aborted
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_MAX = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;
  state_t state, state_n;
  logic [ITER_W-1:0] target, target_n, cnt_n, cnt_inc;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic start_ok, busy_n, to_n, ab_n;
  assign cnt_inc = o_iter_count + 1'b1;
  // A zero-iteration start keeps the FSM in IDLE but still pulses busy for one cycle; the !o_busy term blocks a retrigger during it.
  assign start_ok = (state == IDLE) && i_start && !o_busy;
  // Next-state and next-output logic; abort overrides every other transition out of a non-IDLE state.
  always_comb begin
    state_n = state;
    target_n = target;
    cnt_n = o_iter_count;
    tcnt_n = tcnt;
    gcnt_n = gcnt;
    to_n = o_timeout;
    ab_n = o_aborted;
    case (state)
      IDLE: if (start_ok) begin
        target_n = i_iterations;
        cnt_n = '0;
        to_n = 1'b0;
        ab_n = 1'b0;
        state_n = (i_iterations != '0) ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        tcnt_n = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        tcnt_n = tcnt + 1'b1;
        if (i_done) begin
          cnt_n = cnt_inc;
          gcnt_n = '0;
          state_n = (cnt_inc == target) ? IDLE : GAP;
        end else if (tcnt == T_MAX) begin
          to_n = 1'b1;
          state_n = IDLE;
        end
      end
      GAP: begin
        gcnt_n = gcnt + 1'b1;
        state_n = (gcnt == G_MAX) ? LAUNCH : GAP;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && i_abort) begin
      state_n = IDLE;
      cnt_n = o_iter_count;
      to_n = o_timeout;
      ab_n = 1'b1;
    end
    busy_n = (state_n != IDLE) || start_ok;
  end
  // State and registered outputs; async reset returns everything to IDLE with outputs low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      target <= '0;
      tcnt <= '0;
      gcnt <= '0;
      o_busy <= 1'b0;
      o_pattern_en <= 1'b0;
      o_iter_count <= '0;
      o_timeout <= 1'b0;
      o_aborted <= 1'b0;
    end else begin
      state <= state_n;
      target <= target_n;
      tcnt <= tcnt_n;
      gcnt <= gcnt_n;
      o_busy <= busy_n;
      o_pattern_en <= (state_n == LAUNCH);
      o_iter_count <= cnt_n;
      o_timeout <= to_n;
      o_aborted <= ab_n;
    end
  end
endmodule
